banda_iesire: RTL

BANDA_IESIRE -- requirements
Module: banda_iesire

---
 rtl/banda_iesire.sv | 111 +++++++++++
 1 files changed

// File: rtl/banda_iesire.sv
// rtl/banda_iesire.sv - belt-end output buffer feeding the packing station
// Circular FIFO with registered stall, sticky overflow, delivered-item counter and level FSM.
module banda_iesire #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [W-1:0]               in_data,
   output logic                       in_stall,
   output logic                       out_valid,
   output logic [W-1:0]               out_data,
   input  logic                       out_ready,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     level,
   output logic [1:0]                 state,
   output logic [15:0]                count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   typedef enum logic [1:0] {
      GOL   = 2'b00,
      ACTIV = 2'b01,
      PLIN  = 2'b10
   } stare_t;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level_q;
   logic [LW-1:0] level_d;
   logic [15:0]   count_q;
   logic          overflow_q;
   stare_t        state_q;
   stare_t        state_d;
   logic          push;
   logic          pop;

   // Stall and valid come only from registered level, so out_ready never reaches in_stall.
   assign in_stall  = (level_q == FULL);
   assign out_valid = (level_q != '0);
   assign out_data  = mem[rd_ptr];
   assign level     = level_q;
   assign state     = state_q;
   assign count     = count_q;
   assign overflow  = overflow_q;

   assign push = in_valid && !in_stall && !flush;
   assign pop  = out_valid && out_ready && !flush;

   always_comb begin
      level_d = level_q;
      if (flush) begin
         level_d = '0;
      end else begin
         case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         GOL:     if (push) state_d = ACTIV;
         ACTIV: begin
            if (level_d == FULL)    state_d = PLIN;
            else if (level_d == '0) state_d = GOL;
         end
         PLIN:    if (pop) state_d = ACTIV;
         default: state_d = GOL;
      endcase
      if (flush) state_d = GOL;
   end

   // Storage is deliberately left out of reset; level and pointers alone define contents.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= GOL;
      end else begin
         level_q <= level_d;
         state_q <= state_d;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end
         if (pop && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
         if (in_valid && in_stall) overflow_q <= 1'b1;
      end
   end

endmodule
